muldiv: RTL
===========

MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have parameter n, default 32, operand/HI/LO width.
REQ-002 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request an operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu.
REQ-006 SHALL have port a  input  n  rs operand: multiplicand/dividend, or data for mthi/mtlo.
REQ-007 SHALL have port b  input  n  rt operand: multiplier/divisor.
REQ-008 SHALL have port mthi  input  1  write a into HI.
REQ-009 SHALL have port mtlo  input  1  write a into LO.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when HI/LO take a new result.
REQ-012 SHALL have port divzero  output  1  high with done when a div/divu had b==0.
REQ-013 SHALL have port hi  output  n  HI register.
REQ-014 SHALL have port lo  output  n  LO register.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, FINISH; IDLE is the only state in which busy=0.
REQ-016 SHALL, in IDLE with start=1 at edge E0, latch op, operand magnitudes and result-sign flags, and enter MUL (op[1]=0) or DIV (op[1]=1); busy=1 from E0.
REQ-017 SHALL perform one radix-2 iteration per cycle at edges E1..En: shift-add multiply in MUL, restoring divide in DIV.
REQ-018 SHALL, at edge En+1 (FINISH), apply sign correction, write HI/LO, drive done=1 for exactly one cycle, and return to IDLE with busy=0; result latency is n+1 cycles after E0 (33 for n=32).
REQ-019 SHALL write the 2n-bit product as {hi,lo}; signed mult uses two's-complement operands, multu uses unsigned operands.
REQ-020 SHALL write quotient to lo and remainder to hi; signed: quotient truncates toward zero, remainder takes the sign of a.
REQ-021 SHALL produce lo=0x80000000, hi=0 for signed 0x80000000 / 0xFFFFFFFF (n=32), with no trap or flag.
REQ-022 SHALL, on div/divu with b==0 accepted at E0, skip iteration: at E1 write hi=a and lo=all ones, pulse done=1 and divzero=1, and return to IDLE.
REQ-023 SHALL keep hi/lo at their previous values throughout MUL/DIV, using separate internal working registers.
REQ-024 SHALL ignore start, mthi and mtlo while busy=1.
REQ-025 SHALL, in IDLE, give start priority over mthi/mtlo in the same cycle, so the moves are dropped.
REQ-026 SHALL, in IDLE without start, write hi<=a on mthi and lo<=a on mtlo at the next edge, both if both are asserted; done is not pulsed.
REQ-027 SHALL keep divzero=0 whenever done=0 and on every non-divide completion.
REQ-028 SHALL accept a new start in the cycle immediately after done.

Reset
REQ-029 SHALL, with reset=1 at a rising edge, force state=IDLE, busy=0, done=0, divzero=0, hi=0, lo=0, and clear all working registers.
REQ-030 SHALL abort any in-flight operation on reset without writing its result; reset has priority over start, mthi and mtlo.

Verification
REQ-031 SHALL cover mult: a=0xFFFFFFFE, b=3 -> 33 cycles later done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high for 33 cycles.
REQ-032 SHALL cover multu: a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; mult with a=b=0x80000000 -> hi=0x40000000, lo=0.
REQ-033 SHALL cover divide: div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/2 -> lo=3, hi=1; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 SHALL cover divide-by-zero: divu a=5, b=0 -> one cycle later done=1, divzero=1, hi=5, lo=0xFFFFFFFF; busy low the following cycle.
REQ-035 SHALL cover ignored requests: start and mthi pulsed during busy -> ignored, and hi/lo hold old values until FINISH; mthi+mtlo with a=0x1234 in IDLE -> hi=lo=0x1234 with no done pulse.
REQ-036 SHALL cover reset mid-operation: reset asserted at cycle 10 of a mult -> next cycle busy=0, hi=lo=0, no done pulse; a start on the following cycle is accepted.

Source files
------------

// File: rtl/muldiv.sv
// muldiv: iterative MIPS-style multiply/divide unit with HI/LO registers.
// Runs one radix-2 step per clock: shift-add for multiply, restoring
// subtraction for divide. Sign handling is magnitude-based, with the
// result sign fixed up in a final cycle.
//
// Ports
//   clock    sole clock, rising edge
//   reset    synchronous, active-high
//   start    request an operation (sampled in IDLE only)
//   op       00 mult, 01 multu, 10 div, 11 divu
//   a, b     rs / rt operands (a is also the mthi/mtlo data)
//   mthi     write a into HI (IDLE, no start)
//   mtlo     write a into LO (IDLE, no start)
//   busy     high whenever not IDLE
//   done     one-cycle pulse when HI/LO take a new result
//   divzero  high with done when a divide had b == 0
//   hi, lo   HI / LO registers
//
// state  | meaning
// IDLE   | waiting; accepts start or mthi/mtlo
// MUL    | one shift-add step per cycle, n cycles
// DIV    | one restoring-divide step per cycle, n cycles (1 cycle if b == 0)
// FINISH | sign-correct and write HI/LO, pulse done
module muldiv #(
  parameter int n = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         mthi,
  input  logic         mtlo,
  output logic         busy,
  output logic         done,
  output logic         divzero,
  output logic [n-1:0] hi,
  output logic [n-1:0] lo
);

  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} state_t;

  state_t         r_state, w_next;
  logic [CW-1:0]  r_cnt;
  logic [n-1:0]   r_wa;       // multiplicand or divisor magnitude (raw a on divide-by-zero)
  logic [2*n-1:0] r_wp;       // product, or {remainder, quotient}
  logic           r_is_div;
  logic           r_neg_lo;   // negate product (mult) or quotient (div)
  logic           r_neg_hi;   // negate remainder
  logic           r_dz;

  logic           w_a_neg, w_b_neg, w_b_zero;
  logic [n-1:0]   w_a_mag, w_b_mag;
  logic [n:0]     w_sum;
  logic [2*n-1:0] w_mul_step;
  logic [n:0]     w_shift;
  logic           w_ge;
  logic [n-1:0]   w_diff;
  logic [2*n-1:0] w_div_step;
  logic [2*n-1:0] w_prod;
  logic [n-1:0]   w_quo, w_rem;

  // op[0] selects unsigned; signed ops work on magnitudes.
  assign w_a_neg  = ~op[0] & a[n-1];
  assign w_b_neg  = ~op[0] & b[n-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;
  assign w_b_zero = (b == '0);

  // Multiply: add multiplicand into the upper half when the lsb is set,
  // then shift the whole register right, carry included.
  assign w_sum      = {1'b0, r_wp[2*n-1:n]} + (r_wp[0] ? {1'b0, r_wa} : '0);
  assign w_mul_step = {w_sum, r_wp[n-1:1]};

  // Divide: shift next dividend bit into the remainder and try subtracting.
  // The n-bit difference is exact whenever the subtraction succeeds.
  assign w_shift    = {r_wp[2*n-1:n], r_wp[n-1]};
  assign w_ge       = (w_shift >= {1'b0, r_wa});
  assign w_diff     = w_shift[n-1:0] - r_wa;
  assign w_div_step = w_ge ? {w_diff, r_wp[n-2:0], 1'b1}
                           : {w_shift[n-1:0], r_wp[n-2:0], 1'b0};

  assign w_prod = r_neg_lo ? -r_wp : r_wp;
  assign w_quo  = r_neg_lo ? -r_wp[n-1:0] : r_wp[n-1:0];
  assign w_rem  = r_neg_hi ? -r_wp[2*n-1:n] : r_wp[2*n-1:n];

  assign busy = (r_state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = op[1] ? DIV : MUL;
      MUL:     if (r_cnt == CW'(1)) w_next = FINISH;
      DIV:     if (r_dz) w_next = IDLE;
               else if (r_cnt == CW'(1)) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_wa     <= '0;
      r_wp     <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dz     <= 1'b0;
      done     <= 1'b0;
      divzero  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done    <= 1'b0;
      divzero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt    <= CW'(n);
            r_is_div <= op[1];
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= w_a_neg;
            r_dz     <= op[1] & w_b_zero;
            if (op[1]) begin
              r_wa <= w_b_zero ? a : w_b_mag;
              r_wp <= {{n{1'b0}}, w_a_mag};
            end else begin
              r_wa <= w_a_mag;
              r_wp <= {{n{1'b0}}, w_b_mag};
            end
          end else begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
          end
        end
        MUL: begin
          r_wp  <= w_mul_step;
          r_cnt <= r_cnt - 1'b1;
        end
        DIV: begin
          if (r_dz) begin
            hi      <= r_wa;
            lo      <= '1;
            done    <= 1'b1;
            divzero <= 1'b1;
          end else begin
            r_wp  <= w_div_step;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FINISH: begin
          done <= 1'b1;
          if (r_is_div) begin
            hi <= w_rem;
            lo <= w_quo;
          end else begin
            {hi, lo} <= w_prod;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
